// File: rtl/seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl
// Time-multiplexed scan controller for a common-digit 7-segment display.
// One shared bcd_to_segment decoder is fed with each digit in turn. The
// matching digit-select line is driven for that digit's slot, and each slot
// starts with a short dead time so the previous digit does not ghost.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   load         one-cycle request to take bcd_in as the next displayed value
//   bcd_in       NUM_DIGITS packed BCD digits, digit 0 in bits [3:0]
//   blank_lz     enable leading-zero blanking (sampled live)
//   blink_mask   per-digit blink enable (sampled live)
//   load_ack     one-cycle pulse when a loaded value becomes visible
//   bcd_out      digit value to the decoder, 4'hF means blank
//   dig_sel      one-hot digit select, polarity set by DIG_ACTIVE_LOW
//   frame_start  one-cycle pulse on the first cycle of digit-0 after a wrap
// ---------------------------------------------------------------------------
module seg_scan_ctrl #(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int DEAD           = 16,
    parameter int BLINK_FRAMES   = 64,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   bcd_in,
    input  logic                      blank_lz,
    input  logic [NUM_DIGITS-1:0]     blink_mask,
    output logic                      load_ack,
    output logic [3:0]                bcd_out,
    output logic [NUM_DIGITS-1:0]     dig_sel,
    output logic                      frame_start
);

    localparam int W  = 4 * NUM_DIGITS;
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CW-1:0] C_LAST   = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEAD_C   = CW'(DEAD);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [FW-1:0] F_LAST   = FW'(BLINK_FRAMES - 1);
    localparam logic [NUM_DIGITS-1:0] SEL_IDLE =
        (DIG_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    // Bit i set when digits i..NUM_DIGITS-1 of v are all zero.
    function automatic logic [NUM_DIGITS-1:0] lead_zero_mask(input logic [W-1:0] v);
        logic [NUM_DIGITS-1:0] m;
        logic                  run;
        m   = {NUM_DIGITS{1'b0}};
        run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            run  = run & (v[4*i +: 4] == 4'h0);
            m[i] = run;
        end
        return m;
    endfunction

    // State registers
    logic [CW-1:0]         c_r;
    logic [IW-1:0]         idx_r;
    logic [W-1:0]          active_r;
    logic [W-1:0]          pending_r;
    logic                  pend_vld_r;
    logic                  blink_r;
    logic [FW-1:0]         frame_r;
    logic [3:0]            bcd_out_r;
    logic [NUM_DIGITS-1:0] dig_sel_r;
    logic                  load_ack_r;
    logic                  frame_start_r;

    // Next-state and next-output signals
    logic                  c_last_s;
    logic                  boundary_s;
    logic [CW-1:0]         c_nx_s;
    logic [IW-1:0]         idx_nx_s;
    logic [W-1:0]          pend_src_s;
    logic                  pend_any_s;
    logic [W-1:0]          active_nx_s;
    logic [W-1:0]          pending_nx_s;
    logic                  pend_vld_nx_s;
    logic                  blink_nx_s;
    logic [FW-1:0]         frame_nx_s;
    logic                  ack_nx_s;
    logic [NUM_DIGITS-1:0] onehot_s;
    logic [NUM_DIGITS-1:0] lz_s;
    logic [NUM_DIGITS-1:0] blank_vec_s;
    logic                  blank_sel_s;
    logic [3:0]            digit_s;
    logic [3:0]            bcd_nx_s;
    logic [NUM_DIGITS-1:0] on_s;
    logic [NUM_DIGITS-1:0] dig_nx_s;

    // Scan position, buffer handover, blink timing and the outputs for the
    // upcoming cycle. Outputs are derived from next-state values so the
    // registered outputs line up with the slot they describe.
    always_comb begin
        c_last_s      = (c_r == C_LAST);
        boundary_s    = c_last_s && (idx_r == IDX_LAST);
        c_nx_s        = c_r + CW'(1);
        idx_nx_s      = idx_r;
        active_nx_s   = active_r;
        pending_nx_s  = pending_r;
        pend_vld_nx_s = pend_vld_r;
        blink_nx_s    = blink_r;
        frame_nx_s    = frame_r;
        ack_nx_s      = 1'b0;

        if (c_last_s) begin
            c_nx_s = {CW{1'b0}};
            if (idx_r == IDX_LAST) begin
                idx_nx_s = {IW{1'b0}};
            end else begin
                idx_nx_s = idx_r + IW'(1);
            end
        end else begin
            c_nx_s = c_r + CW'(1);
        end

        // A load in the boundary cycle bypasses the pending register.
        pend_src_s = load ? bcd_in : pending_r;
        pend_any_s = load | pend_vld_r;

        if (boundary_s) begin
            if (pend_any_s) begin
                active_nx_s = pend_src_s;
            end else begin
                active_nx_s = active_r;
            end
            ack_nx_s      = pend_any_s;
            pending_nx_s  = {W{1'b0}};
            pend_vld_nx_s = 1'b0;
            if (frame_r == F_LAST) begin
                frame_nx_s = {FW{1'b0}};
                blink_nx_s = ~blink_r;
            end else begin
                frame_nx_s = frame_r + FW'(1);
            end
        end else begin
            pending_nx_s  = pend_src_s;
            pend_vld_nx_s = pend_any_s;
        end

        for (int i = 0; i < NUM_DIGITS; i++) begin
            onehot_s[i] = (idx_nx_s == IW'(i));
        end

        lz_s = lead_zero_mask(active_nx_s);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            blank_vec_s[i] = (blank_lz && (i != 0) && lz_s[i]) ||
                             (blink_nx_s && blink_mask[i]);
        end
        blank_sel_s = |(blank_vec_s & onehot_s);

        digit_s = 4'h0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            digit_s = digit_s | (active_nx_s[4*i +: 4] & {4{onehot_s[i]}});
        end
        bcd_nx_s = blank_sel_s ? 4'hF : digit_s;

        // Dead time at the start of every slot keeps all digits off.
        on_s     = onehot_s & {NUM_DIGITS{(c_nx_s >= DEAD_C)}};
        dig_nx_s = (DIG_ACTIVE_LOW != 0) ? ~on_s : on_s;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            c_r           <= {CW{1'b0}};
            idx_r         <= {IW{1'b0}};
            active_r      <= {W{1'b0}};
            pending_r     <= {W{1'b0}};
            pend_vld_r    <= 1'b0;
            blink_r       <= 1'b0;
            frame_r       <= {FW{1'b0}};
            bcd_out_r     <= 4'hF;
            dig_sel_r     <= SEL_IDLE;
            load_ack_r    <= 1'b0;
            frame_start_r <= 1'b0;
        end else begin
            c_r           <= c_nx_s;
            idx_r         <= idx_nx_s;
            active_r      <= active_nx_s;
            pending_r     <= pending_nx_s;
            pend_vld_r    <= pend_vld_nx_s;
            blink_r       <= blink_nx_s;
            frame_r       <= frame_nx_s;
            bcd_out_r     <= bcd_nx_s;
            dig_sel_r     <= dig_nx_s;
            load_ack_r    <= ack_nx_s;
            frame_start_r <= boundary_s;
        end
    end

    assign load_ack    = load_ack_r;
    assign bcd_out     = bcd_out_r;
    assign dig_sel     = dig_sel_r;
    assign frame_start = frame_start_r;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_ctrl
// Self-checking bench for seg_scan_ctrl with NUM_DIGITS=4, SCAN_DIV=8,
// DEAD=2, BLINK_FRAMES=2, active-low digit select. A reference model works
// from the cycle number since reset: slot, digit and frame come from plain
// division, and the displayed value follows the load/frame rules.
// ---------------------------------------------------------------------------
module tb_seg_scan_ctrl;

    localparam int N  = 4;
    localparam int S  = 8;
    localparam int D  = 2;
    localparam int BF = 2;
    localparam int FL = N * S;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load = 1'b0;
    logic [15:0]   bcd_in = 16'h0000;
    logic          blank_lz = 1'b0;
    logic [3:0]    blink_mask = 4'h0;
    logic          load_ack;
    logic [3:0]    bcd_out;
    logic [3:0]    dig_sel;
    logic          frame_start;

    seg_scan_ctrl #(
        .NUM_DIGITS(N), .SCAN_DIV(S), .DEAD(D),
        .BLINK_FRAMES(BF), .DIG_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .bcd_in(bcd_in),
        .blank_lz(blank_lz), .blink_mask(blink_mask), .load_ack(load_ack),
        .bcd_out(bcd_out), .dig_sel(dig_sel), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc;
    int          ack_count;
    int          last_ack_cyc;
    logic [15:0] m_active;
    logic [15:0] m_pend;
    logic        m_pv;
    logic [3:0]  exp_dig;
    logic [3:0]  exp_bcd;
    logic        exp_ack;
    logic        exp_fs;

    task automatic do_reset();
        load  = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n        = 1'b1;
        cyc          = 0;
        m_active     = 16'h0000;
        m_pend       = 16'h0000;
        m_pv         = 1'b0;
        exp_dig      = 4'hF;
        exp_bcd      = 4'hF;
        exp_ack      = 1'b0;
        exp_fs       = 1'b0;
        ack_count    = 0;
        last_ack_cyc = -1;
    endtask

    // Drive one cycle of inputs, advance the model, and clock the DUT.
    task automatic advance(input logic ld, input logic [15:0] val,
                           input logic blz, input logic [3:0] msk);
        int          c;
        int          ix;
        int          ph;
        logic        boundary;
        logic [15:0] up;
        load       = ld;
        bcd_in     = val;
        blank_lz   = blz;
        blink_mask = msk;
        boundary   = ((cyc % FL) == FL - 1);
        if (ld) begin
            m_pend = val;
            m_pv   = 1'b1;
        end
        exp_ack = boundary && m_pv;
        exp_fs  = boundary;
        if (boundary && m_pv) begin
            m_active = m_pend;
            m_pv     = 1'b0;
        end
        cyc++;
        c  = cyc % S;
        ix = (cyc / S) % N;
        ph = ((cyc / FL) / BF) % 2;
        exp_dig = (c < D) ? 4'b1111 : ~(4'b0001 << ix);
        up      = m_active >> (4 * ix);
        exp_bcd = ((blz && ix > 0 && up == 16'h0000) || (ph == 1 && msk[ix])) ? 4'hF : up[3:0];
        @(posedge clk);
        #1;
        load = 1'b0;
        if (load_ack === 1'b1) begin
            ack_count++;
            last_ack_cyc = cyc;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({dig_sel, bcd_out, load_ack, frame_start} !== {4'b1111, 4'hF, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset got dig=%b bcd=%h ack=%b fs=%b, expected dig=1111 bcd=f ack=0 fs=0",
                     dig_sel, bcd_out, load_ack, frame_start);
        end
    endtask

    task automatic test_scan();
        int first_fs;
        do_reset();
        first_fs = -1;
        for (int k = 0; k < 40; k++) begin
            advance(1'b0, 16'h0000, 1'b0, 4'h0);
            if (frame_start === 1'b1 && first_fs < 0) first_fs = cyc;
            checks++;
            if ({dig_sel, bcd_out, load_ack, frame_start} !== {exp_dig, exp_bcd, exp_ack, exp_fs}) begin
                errors++;
                $display("FAIL scan cyc=%0d got dig=%b bcd=%h ack=%b fs=%b, expected dig=%b bcd=%h ack=%b fs=%b",
                         cyc, dig_sel, bcd_out, load_ack, frame_start, exp_dig, exp_bcd, exp_ack, exp_fs);
            end
        end
        checks++;
        if (first_fs != 32) begin
            errors++;
            $display("FAIL scan_first_frame_start got cycle %0d, expected 32", first_fs);
        end
    endtask

    task automatic test_load();
        logic [3:0] d [0:3];
        do_reset();
        for (int k = 0; k < 64; k++) begin
            advance(cyc == 5, 16'h1234, 1'b0, 4'h0);
            if (cyc >= 32 && (cyc % S) == 4) d[(cyc / S) % N] = bcd_out;
            checks++;
            if ({dig_sel, bcd_out, load_ack, frame_start} !== {exp_dig, exp_bcd, exp_ack, exp_fs}) begin
                errors++;
                $display("FAIL load cyc=%0d got dig=%b bcd=%h ack=%b fs=%b, expected dig=%b bcd=%h ack=%b fs=%b",
                         cyc, dig_sel, bcd_out, load_ack, frame_start, exp_dig, exp_bcd, exp_ack, exp_fs);
            end
        end
        checks++;
        if (ack_count != 1 || last_ack_cyc != 32) begin
            errors++;
            $display("FAIL load_ack got count=%0d at cycle %0d, expected count=1 at cycle 32", ack_count, last_ack_cyc);
        end
        checks++;
        if ({d[0], d[1], d[2], d[3]} !== 16'h4321) begin
            errors++;
            $display("FAIL load_digits got %h%h%h%h, expected 4321", d[0], d[1], d[2], d[3]);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] d [0:3];
        do_reset();
        for (int k = 0; k < 64; k++) begin
            advance(cyc == 3 || cyc == 20, (cyc == 3) ? 16'h1111 : 16'h9876, 1'b0, 4'h0);
            if (cyc >= 32 && (cyc % S) == 4) d[(cyc / S) % N] = bcd_out;
            checks++;
            if ({dig_sel, bcd_out, load_ack, frame_start} !== {exp_dig, exp_bcd, exp_ack, exp_fs}) begin
                errors++;
                $display("FAIL b2b cyc=%0d got dig=%b bcd=%h ack=%b fs=%b, expected dig=%b bcd=%h ack=%b fs=%b",
                         cyc, dig_sel, bcd_out, load_ack, frame_start, exp_dig, exp_bcd, exp_ack, exp_fs);
            end
        end
        checks++;
        if (ack_count != 1 || last_ack_cyc != 32) begin
            errors++;
            $display("FAIL b2b_ack got count=%0d at cycle %0d, expected count=1 at cycle 32", ack_count, last_ack_cyc);
        end
        checks++;
        if ({d[0], d[1], d[2], d[3]} !== 16'h6789) begin
            errors++;
            $display("FAIL b2b_digits got %h%h%h%h, expected 6789", d[0], d[1], d[2], d[3]);
        end
    endtask

    task automatic test_boundary_load();
        do_reset();
        for (int k = 0; k < 40; k++) begin
            advance(cyc == 31, 16'hABC7, 1'b0, 4'h0);
            checks++;
            if ({dig_sel, bcd_out, load_ack, frame_start} !== {exp_dig, exp_bcd, exp_ack, exp_fs}) begin
                errors++;
                $display("FAIL bnd cyc=%0d got dig=%b bcd=%h ack=%b fs=%b, expected dig=%b bcd=%h ack=%b fs=%b",
                         cyc, dig_sel, bcd_out, load_ack, frame_start, exp_dig, exp_bcd, exp_ack, exp_fs);
            end
            if (cyc == 32) begin
                checks++;
                if ({bcd_out, load_ack, frame_start} !== {4'h7, 1'b1, 1'b1}) begin
                    errors++;
                    $display("FAIL bnd_bypass got bcd=%h ack=%b fs=%b, expected bcd=7 ack=1 fs=1",
                             bcd_out, load_ack, frame_start);
                end
            end
        end
    endtask

    task automatic test_lz();
        logic [15:0] shot [0:2];
        logic        blz;
        do_reset();
        for (int k = 0; k < 128; k++) begin
            blz = (cyc < 95);
            advance(cyc == 0 || cyc == 40 || cyc == 72,
                    (cyc == 40) ? 16'h0000 : 16'h0050, blz, 4'h0);
            if ((cyc % S) == 4 && cyc >= 32) shot[cyc / FL - 1][4 * ((cyc / S) % N) +: 4] = bcd_out;
            checks++;
            if ({dig_sel, bcd_out, load_ack, frame_start} !== {exp_dig, exp_bcd, exp_ack, exp_fs}) begin
                errors++;
                $display("FAIL lz cyc=%0d got dig=%b bcd=%h ack=%b fs=%b, expected dig=%b bcd=%h ack=%b fs=%b",
                         cyc, dig_sel, bcd_out, load_ack, frame_start, exp_dig, exp_bcd, exp_ack, exp_fs);
            end
        end
        checks++;
        if (shot[0] !== 16'hFF50 || shot[1] !== 16'hFFF0 || shot[2] !== 16'h0050) begin
            errors++;
            $display("FAIL lz_slots got %h %h %h, expected ff50 fff0 0050", shot[0], shot[1], shot[2]);
        end
    endtask

    task automatic test_blink();
        logic [3:0] d0 [0:5];
        logic [3:0] d1 [0:5];
        do_reset();
        for (int k = 0; k < 192; k++) begin
            advance(cyc == 0, 16'h1234, 1'b0, 4'b0001);
            if ((cyc % FL) == 4) d0[cyc / FL] = bcd_out;
            if ((cyc % FL) == 12) d1[cyc / FL] = bcd_out;
            checks++;
            if ({dig_sel, bcd_out, load_ack, frame_start} !== {exp_dig, exp_bcd, exp_ack, exp_fs}) begin
                errors++;
                $display("FAIL blink cyc=%0d got dig=%b bcd=%h ack=%b fs=%b, expected dig=%b bcd=%h ack=%b fs=%b",
                         cyc, dig_sel, bcd_out, load_ack, frame_start, exp_dig, exp_bcd, exp_ack, exp_fs);
            end
        end
        checks++;
        if ({d0[1], d0[2], d0[3], d0[4], d0[5]} !== 20'h4FF44) begin
            errors++;
            $display("FAIL blink_digit0 got %h%h%h%h%h, expected 4ff44", d0[1], d0[2], d0[3], d0[4], d0[5]);
        end
        checks++;
        if ({d1[1], d1[2], d1[3], d1[4], d1[5]} !== 20'h33333) begin
            errors++;
            $display("FAIL blink_digit1 got %h%h%h%h%h, expected 33333", d1[1], d1[2], d1[3], d1[4], d1[5]);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 0; k < 13; k++) begin
            advance(cyc == 10, 16'h5555, 1'b0, 4'h0);
        end
        do_reset();
        checks++;
        if ({dig_sel, bcd_out, load_ack, frame_start} !== {4'b1111, 4'hF, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL rstmid got dig=%b bcd=%h ack=%b fs=%b, expected dig=1111 bcd=f ack=0 fs=0",
                     dig_sel, bcd_out, load_ack, frame_start);
        end
        for (int k = 0; k < 72; k++) begin
            advance(1'b0, 16'h0000, 1'b0, 4'h0);
            checks++;
            if ({dig_sel, bcd_out, load_ack, frame_start} !== {exp_dig, exp_bcd, exp_ack, exp_fs}) begin
                errors++;
                $display("FAIL rstmid cyc=%0d got dig=%b bcd=%h ack=%b fs=%b, expected dig=%b bcd=%h ack=%b fs=%b",
                         cyc, dig_sel, bcd_out, load_ack, frame_start, exp_dig, exp_bcd, exp_ack, exp_fs);
            end
        end
        checks++;
        if (ack_count != 0) begin
            errors++;
            $display("FAIL rstmid_ack got %0d acks, expected 0", ack_count);
        end
    endtask

    task automatic test_random();
        logic        ld;
        logic        blz;
        logic [3:0]  msk;
        logic [15:0] val;
        do_reset();
        blz = 1'b0;
        msk = 4'h0;
        for (int k = 0; k < 400; k++) begin
            ld  = ($urandom_range(0, 11) == 0);
            val = 16'($urandom);
            if ($urandom_range(0, 29) == 0) blz = ~blz;
            if ($urandom_range(0, 39) == 0) msk = 4'($urandom);
            advance(ld, val, blz, msk);
            checks++;
            if ({dig_sel, bcd_out, load_ack, frame_start} !== {exp_dig, exp_bcd, exp_ack, exp_fs}) begin
                errors++;
                $display("FAIL random cyc=%0d got dig=%b bcd=%h ack=%b fs=%b, expected dig=%b bcd=%h ack=%b fs=%b",
                         cyc, dig_sel, bcd_out, load_ack, frame_start, exp_dig, exp_bcd, exp_ack, exp_fs);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_load();
        test_back_to_back();
        test_boundary_load();
        test_lz();
        test_blink();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for a common-digit 7-segment display. Sequences NUM_DIGITS BCD digits through one shared bcd_to_segment decoder and drives the matching digit-select line. Features:
- Per-digit dwell with anti-ghosting dead time.
- Frame-synchronous double-buffered value update with load/ack handshake.
- Leading-zero blanking and per-digit blink.

Sits between the counter/datapath logic and the board display pins.

Parameters:
- NUM_DIGITS, 4: digits scanned per frame (2..8).
- SCAN_DIV, 50000: clocks per digit slot (>= DEAD+2).
- DEAD, 16: clocks at the start of each slot with all digits deselected (0 allowed).
- BLINK_FRAMES, 64: frames per blink half-period (>= 1).
- DIG_ACTIVE_LOW, 1: 1 = selected digit drives 0; 0 = selected digit drives 1.

Ports:
- clk, input, 1: system clock; all logic on rising edge.
- rst_n, input, 1: synchronous active-low reset.
- load, input, 1: one-cycle request to update the displayed value.
- bcd_in, input, 4*NUM_DIGITS: digit i is bcd_in[4i+3:4i]; digit 0 is least significant.
- blank_lz, input, 1: enable leading-zero blanking.
- blink_mask, input, NUM_DIGITS: bit i = 1 makes digit i blink.
- load_ack, output, 1: one-cycle pulse; the new value is now displayed.
- bcd_out, output, 4: to the bcd_to_segment input; 4'hF = blank (decoder default off).
- dig_sel, output, NUM_DIGITS: one-hot digit select; polarity per DIG_ACTIVE_LOW.
- frame_start, output, 1: one-cycle pulse on the first cycle of each digit-0 slot after a wrap.

Behaviour:
- Reset (rst_n=0 at a clk edge) sets:
  - slot counter c=0, digit index idx=0;
  - active register all zero; pending flag clear; pending register zero;
  - blink_phase=0, frame counter=0;
  - dig_sel all inactive, bcd_out=4'hF, load_ack=0, frame_start=0.
  - Reset mid-frame or mid-handshake discards the pending value; no ack is issued.
- Scan:
  - c counts 0..SCAN_DIV-1.
  - At c=SCAN_DIV-1: c->0 and idx->idx+1; idx wraps from NUM_DIGITS-1 to 0 ("frame boundary").
  - The first cycle after reset release is c=0, idx=0; frame_start is not pulsed for it.
- Outputs:
  - All outputs are registered, computed from the next-state (idx, c), so they align with the slot they describe. Zero added latency.
  - dig_sel: bit idx is active for c in [DEAD, SCAN_DIV-1]; all bits inactive for c < DEAD.
  - bcd_out: active digit idx for the whole slot, unless blanked, in which case 4'hF.
  - Non-BCD values 10..15 pass through unchanged; the decoder blanks them.
- Blanking. Digit i is blanked if either condition holds:
  - Leading zero: blank_lz=1, i>0, and active digits i..NUM_DIGITS-1 are all 0. Digit 0 is never LZ-blanked.
  - Blink: blink_phase=1 and blink_mask[i]=1.
  - blank_lz and blink_mask are sampled live each cycle; they are not buffered.
- Blink timing: the frame counter increments at each frame boundary. When it reaches BLINK_FRAMES-1, it clears and blink_phase toggles.
- Load handshake:
  - load=1 captures bcd_in into the pending register and sets the pending flag.
  - A load while pending overwrites the pending value (latest wins; a single ack follows).
  - At a frame boundary with pending set: active <= pending, pending clears, and load_ack pulses in the first cycle of the new frame (same cycle as frame_start).
  - A load coinciding with the frame-boundary cycle: that cycle's bcd_in goes straight to active; ack is as above.
  - The active value never changes mid-frame.
  - load=0 with no pending value: no ack, and active is unchanged.

Test Plan (NUM_DIGITS=4, SCAN_DIV=8, DEAD=2, BLINK_FRAMES=2, DIG_ACTIVE_LOW=1):
1. Reset, then run 40 cycles -> bcd_out=0 in every slot. dig_sel is 4'b1111 for c=0..1, then 1110/1101/1011/0111 for c=2..7 of slots 0..3. frame_start first pulses at cycle 32.
2. load with bcd_in=16'h1234 at cycle 5 -> displayed value stays 0 until cycle 32. At cycle 32: load_ack=1 and frame_start=1. Slots then show 4,3,2,1.
3. Two loads (16'h1111 at cycle 3, then 16'h9876 at cycle 20) -> exactly one load_ack, at cycle 32. Digits show 6,7,8,9.
4. Active value 16'h0050 with blank_lz=1 -> slots show 0,5,F,F. With 16'h0000 -> 0,F,F,F. Setting blank_lz=0 -> 0,5,0,0.
5. blink_mask=4'b0001 with value 16'h1234 -> digit 0 shows 4 in frames 0-1, F in frames 2-3, 4 in frames 4-5. Other digits are unaffected.
6. Assert rst_n=0 for 1 cycle mid-slot with a load pending -> next cycle: c=0, idx=0, dig_sel=1111, bcd_out=F. No load_ack is ever issued for the discarded load.
